// File: rtl/parking_slot_allocator.sv
// Free-slot bitmap writer for an 8-slot lot: grants the lowest free slot over a
// four-phase entry handshake and releases slots on single-cycle exit strobes.
module parking_slot_allocator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    output logic       entry_ack,
    output logic       entry_nak,
    output logic [2:0] entry_slot,
    input  logic       exit_valid,
    input  logic [2:0] exit_slot,
    output logic       exit_done,
    output logic       exit_err,
    output logic [7:0] new_capacity,
    output logic [3:0] free_cnt,
    output logic [3:0] parked_cnt,
    output logic       lot_full,
    output logic       lot_empty
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DENY
    } state_t;

    state_t     state;
    logic [2:0] lowest_free;
    logic       any_free;
    logic       grant_now;
    logic       deny_now;
    logic       exit_hit;
    logic       exit_miss;
    logic [7:0] cap_next;
    logic [3:0] free_next;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Scanning downward leaves the lowest set index as the final assignment.
    always_comb begin
        lowest_free = '0;
        any_free    = |new_capacity;
        for (int i = 7; i >= 0; i--) begin
            if (new_capacity[i]) begin
                lowest_free = 3'(i);
            end
        end
    end

    // Both decisions look at the pre-edge bitmap, so a slot released on this
    // edge is never granted on the same edge.
    assign grant_now = (state == IDLE) && entry_req && any_free;
    assign deny_now  = (state == IDLE) && entry_req && !any_free;
    assign exit_hit  = exit_valid && !new_capacity[exit_slot];
    assign exit_miss = exit_valid &&  new_capacity[exit_slot];

    always_comb begin
        cap_next = new_capacity;
        if (grant_now) begin
            cap_next[lowest_free] = 1'b0;
        end
        if (exit_hit) begin
            cap_next[exit_slot] = 1'b1;
        end
    end

    assign free_next = popcount8(cap_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            new_capacity <= 8'hFF;
            free_cnt     <= 4'd8;
            parked_cnt   <= 4'd0;
            lot_full     <= 1'b0;
            lot_empty    <= 1'b1;
            entry_ack    <= 1'b0;
            entry_nak    <= 1'b0;
            entry_slot   <= 3'd0;
            exit_done    <= 1'b0;
            exit_err     <= 1'b0;
        end else begin
            new_capacity <= cap_next;
            free_cnt     <= free_next;
            parked_cnt   <= 4'd8 - free_next;
            lot_full     <= (free_next == 4'd0);
            lot_empty    <= (free_next == 4'd8);
            exit_done    <= exit_hit;
            exit_err     <= exit_miss;

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        entry_ack  <= 1'b1;
                        entry_slot <= lowest_free;
                        state      <= GRANT;
                    end else if (deny_now) begin
                        entry_nak <= 1'b1;
                        state     <= DENY;
                    end
                end
                GRANT: begin
                    if (!entry_req) begin
                        entry_ack <= 1'b0;
                        state     <= IDLE;
                    end
                end
                // A slot freed here does not turn the refusal into a grant.
                DENY: begin
                    if (!entry_req) begin
                        entry_nak <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    entry_ack <= 1'b0;
                    entry_nak <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Directed table plus hand sequences and a randomized reference-model run
// for parking_slot_allocator.
module tb_parking_slot_allocator;

    logic       clk;
    logic       rst_n;
    logic       entry_req;
    logic       entry_ack;
    logic       entry_nak;
    logic [2:0] entry_slot;
    logic       exit_valid;
    logic [2:0] exit_slot;
    logic       exit_done;
    logic       exit_err;
    logic [7:0] new_capacity;
    logic [3:0] free_cnt;
    logic [3:0] parked_cnt;
    logic       lot_full;
    logic       lot_empty;

    int num_checks;
    int num_fails;

    typedef struct {
        logic       req;
        logic       ev;
        logic [2:0] es;
        logic [7:0] cap;
        logic       ack;
        logic       nak;
        logic [2:0] slot;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    parking_slot_allocator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entry_req    (entry_req),
        .entry_ack    (entry_ack),
        .entry_nak    (entry_nak),
        .entry_slot   (entry_slot),
        .exit_valid   (exit_valid),
        .exit_slot    (exit_slot),
        .exit_done    (exit_done),
        .exit_err     (exit_err),
        .new_capacity (new_capacity),
        .free_cnt     (free_cnt),
        .parked_cnt   (parked_cnt),
        .lot_full     (lot_full),
        .lot_empty    (lot_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ones(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) if (v[i]) c = c + 4'd1;
        return c;
    endfunction

    task automatic check_val(input string tag, input string field,
                             input logic [7:0] act, input logic [7:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h at %0t", tag, field, act, exp, $time);
        end
    endtask

    task automatic check_output(input string tag, input logic [7:0] e_cap,
                                input logic e_ack, input logic e_nak,
                                input logic e_chk_slot, input logic [2:0] e_slot,
                                input logic e_done, input logic e_err);
        logic [3:0] e_free;
        e_free = ones(e_cap);
        check_val(tag, "new_capacity", new_capacity, e_cap);
        check_val(tag, "entry_ack", {7'd0, entry_ack}, {7'd0, e_ack});
        check_val(tag, "entry_nak", {7'd0, entry_nak}, {7'd0, e_nak});
        if (e_chk_slot) check_val(tag, "entry_slot", {5'd0, entry_slot}, {5'd0, e_slot});
        check_val(tag, "exit_done", {7'd0, exit_done}, {7'd0, e_done});
        check_val(tag, "exit_err", {7'd0, exit_err}, {7'd0, e_err});
        check_val(tag, "free_cnt", {4'd0, free_cnt}, {4'd0, e_free});
        check_val(tag, "parked_cnt", {4'd0, parked_cnt}, {4'd0, 4'd8 - e_free});
        check_val(tag, "lot_full", {7'd0, lot_full}, {7'd0, e_free == 4'd0});
        check_val(tag, "lot_empty", {7'd0, lot_empty}, {7'd0, e_free == 4'd8});
        check_val(tag, "cnt_sum", {4'd0, free_cnt} + {4'd0, parked_cnt}, 8'd8);
    endtask

    task automatic apply_stimulus(input logic req, input logic ev, input logic [2:0] es);
        entry_req  = req;
        exit_valid = ev;
        exit_slot  = es;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic req, input logic ev, input logic [2:0] es,
                           input logic [7:0] cap, input logic ack, input logic nak,
                           input logic [2:0] slot, input logic done, input logic err);
        vec_t v;
        v.req = req; v.ev = ev; v.es = es; v.cap = cap; v.ack = ack;
        v.nak = nak; v.slot = slot; v.done = done; v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] m_cap;
        logic [7:0] nxt;
        int         m_state;
        logic [2:0] m_slot;
        logic       m_ack, m_nak, m_done, m_err;
        logic       req, ev;
        logic [2:0] es;
        logic [2:0] lo;
        int         grant_order[5];

        num_checks = 0;
        num_fails  = 0;
        rst_n      = 1'b0;
        entry_req  = 1'b0;
        exit_valid = 1'b0;
        exit_slot  = 3'd0;

        // Fill lot: grants 0..7 in order, each followed by a dropped request
        for (int i = 0; i < 8; i++) begin
            c = 8'hFF << (i + 1);
            add_vec(1'b1, 1'b0, 3'd0, c, 1'b1, 1'b0, 3'(i), 1'b0, 1'b0);
            add_vec(1'b0, 1'b0, 3'd0, c, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        end
        // Full lot refusal, exit while refused, re-raise for slot 5
        add_vec(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 3'd5, 8'h20, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 3'd0, 8'h20, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 3'd0, 8'h20, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        // Release 4..7 to reach F0, then a bad exit and a good exit
        add_vec(1'b0, 1'b1, 3'd4, 8'h10, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 3'd5, 8'h30, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 3'd6, 8'h70, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 3'd7, 8'hF0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 3'd6, 8'hF0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b1, 3'd2, 8'hF4, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

        #12;
        check_output("reset", 8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].req, vecs[k].ev, vecs[k].es);
            check_output($sformatf("vec%0d", k), vecs[k].cap, vecs[k].ack, vecs[k].nak,
                         vecs[k].ack, vecs[k].slot, vecs[k].done, vecs[k].err);
        end

        // Drain F4 down to 00 through the lowest-first grant order
        grant_order = '{2, 4, 5, 6, 7};
        c = 8'hF4;
        for (int i = 0; i < 5; i++) begin
            c[grant_order[i]] = 1'b0;
            apply_stimulus(1'b1, 1'b0, 3'd0);
            check_output("drain_ack", c, 1'b1, 1'b0, 1'b1, 3'(grant_order[i]), 1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b0, 3'd0);
            check_output("drain_drop", c, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        end

        // Same-edge entry and exit: full lot refuses, partial lot grants old lowest
        apply_stimulus(1'b1, 1'b1, 3'd3);
        check_output("full_plus_exit", 8'h08, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'd0);
        check_output("deny_drop", 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'd0);
        check_output("grant3", 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'd0);
        check_output("grant3_drop", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'd0);
        check_output("free0", 8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 3'd4);
        check_output("grant_plus_exit", 8'h10, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'd0);
        check_output("gpe_drop", 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 3'd4);
        check_output("grant_vs_err", 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 3'd0);
        check_output("gve_drop", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // Hold a grant of slot 6 while freeing 0..5, then reset asynchronously
        apply_stimulus(1'b0, 1'b1, 3'd6);
        check_output("free6", 8'h40, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'd0);
        check_output("grant6", 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
        c = 8'h00;
        for (int s = 0; s < 6; s++) begin
            c[s] = 1'b1;
            apply_stimulus(1'b1, 1'b1, 3'(s));
            check_output("hold_exit", c, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
        end
        exit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_output("async_reset", 8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 3'd0);
        check_output("post_reset_grant", 8'hFE, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'd0);
        check_output("post_reset_drop", 8'hFE, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // Random interleaving against a behavioural bitmap model
        m_cap = 8'hFE; m_state = 0; m_slot = 3'd0;
        m_ack = 1'b0; m_nak = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (m_state == 0) req = ($urandom_range(0, 1) == 1);
            else              req = ($urandom_range(0, 3) != 0);
            ev = ($urandom_range(0, 1) == 1);
            es = 3'($urandom_range(0, 7));

            m_done = ev && !m_cap[es];
            m_err  = ev &&  m_cap[es];
            nxt = m_cap;
            if (m_state == 0 && req) begin
                if (m_cap != 8'h00) begin
                    lo = 3'd0;
                    for (int j = 0; j < 8; j++) begin
                        if (m_cap[j]) begin
                            lo = 3'(j);
                            break;
                        end
                    end
                    nxt[lo] = 1'b0;
                    m_slot  = lo;
                    m_ack   = 1'b1;
                    m_state = 1;
                end else begin
                    m_nak   = 1'b1;
                    m_state = 2;
                end
            end else if (m_state != 0 && !req) begin
                m_ack   = 1'b0;
                m_nak   = 1'b0;
                m_state = 0;
            end
            if (m_done) nxt[es] = 1'b1;
            m_cap = nxt;

            apply_stimulus(req, ev, es);
            check_output("random", m_cap, m_ack, m_nak, m_ack, m_slot, m_done, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
